// File: rtl/stack_op_sequencer.sv
// Purpose : sequences push/pop/peek strobes to an 8-bit LIFO stack for one stack op per handshake.
// Latency : accept edge to rsp_valid = PUSH 2, POP/TOS/NOT/DUP 3, ADD/SUB/AND 4, rejected op 1.
// Backpr. : cmd_ready is high only in IDLE; cmd_valid is ignored while busy. Optional macro STACK_SEQ_HIWATER_EN.
module stack_op_sequencer #(
  parameter int DEPTH = 31,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [4:0]   depth,
  output logic         st_clr,
  output logic         st_push,
  output logic         st_pop,
  output logic         st_tos,
  output logic [W-1:0] st_din,
  input  logic [W-1:0] st_dout
`ifdef STACK_SEQ_HIWATER_EN
  ,
  output logic [4:0]   hiwater
`endif
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_TOS  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_TOS1,
    S_EXEC,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // latched command and first popped operand (old top of stack)
  logic [2:0]   op_q;
  logic [W-1:0] data_q;
  logic [W-1:0] opa;

  // combinational controls produced by the FSM
  logic         op_ld;
  logic         opa_ld;
  logic         push_nxt;
  logic         rsp_ld;
  logic         rsp_err_nxt;
  logic [W-1:0] rsp_data_nxt;
  logic [W-1:0] res;
  logic         hw_rd;
  logic         err_ovf;
  logic         err_udf;
  logic         cmd_binary;
  logic         q_binary;
  logic [4:0]   depth_nxt;

  // the stack is cleared whenever reset is asserted
  assign st_clr    = ~rst;
  assign cmd_ready = (state == S_IDLE);

  // reject checks on the offered command, evaluated against the current depth
  always_comb begin
    cmd_binary = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_AND);
    q_binary   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);
    err_ovf    = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) && (depth == DEPTH_MAX);
    err_udf    = (((cmd_op == OP_POP) || (cmd_op == OP_TOS) ||
                   (cmd_op == OP_NOT) || (cmd_op == OP_DUP)) && (depth == 5'd0)) ||
                 (cmd_binary && (depth < 5'd2));
`ifdef STACK_SEQ_HIWATER_EN
    hw_rd      = (cmd_op == OP_NOT) && cmd_data[W-1];
`else
    hw_rd      = 1'b0;
`endif
  end

  // ALU: b is the last entry read from the stack, opa the earlier-popped top
  always_comb begin
    res = '0;
    case (op_q)
      OP_PUSH: res = data_q;
      OP_POP:  res = st_dout;
      OP_TOS:  res = st_dout;
      OP_ADD:  res = st_dout + opa;
      OP_SUB:  res = st_dout - opa;
      OP_AND:  res = st_dout & opa;
      OP_NOT:  res = ~st_dout;
      OP_DUP:  res = st_dout;
      default: res = '0;
    endcase
  end

  // next-state and per-cycle control decode
  always_comb begin
    state_nxt    = state;
    op_ld        = 1'b0;
    opa_ld       = 1'b0;
    push_nxt     = 1'b0;
    rsp_ld       = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_ld = 1'b1;
          if (hw_rd) begin
            // hiwater readout answers directly without touching the stack
            state_nxt    = S_RESP;
            rsp_ld       = 1'b1;
`ifdef STACK_SEQ_HIWATER_EN
            rsp_data_nxt = W'(hiwater);
`endif
          end else if (err_ovf || err_udf) begin
            state_nxt    = S_RESP;
            rsp_ld       = 1'b1;
            rsp_err_nxt  = 1'b1;
            rsp_data_nxt = '0;
          end else begin
            case (cmd_op)
              OP_PUSH:         state_nxt = S_EXEC;
              OP_TOS, OP_DUP:  state_nxt = S_TOS1;
              default:         state_nxt = S_POP1;
            endcase
          end
        end
      end
      S_POP1: begin
        state_nxt = q_binary ? S_POP2 : S_EXEC;
      end
      S_POP2: begin
        // st_dout holds the old top popped in POP1
        opa_ld    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_TOS1: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        push_nxt     = (op_q != OP_POP) && (op_q != OP_TOS);
        rsp_ld       = 1'b1;
        rsp_data_nxt = res;
        state_nxt    = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // depth follows the stack head: it moves on the edge where a strobe is seen by the stack
  always_comb begin
    depth_nxt = depth;
    if (st_push) begin
      depth_nxt = depth + 5'd1;
    end else if (st_pop) begin
      depth_nxt = depth - 5'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // registered strobes, response and datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q      <= '0;
      data_q    <= '0;
      opa       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      st_tos    <= 1'b0;
      st_din    <= '0;
      depth     <= '0;
    end else begin
      if (op_ld) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (opa_ld) begin
        opa <= st_dout;
      end
      rsp_valid <= (state_nxt == S_RESP);
      rsp_err   <= rsp_err_nxt;
      if (rsp_ld) begin
        rsp_data <= rsp_data_nxt;
      end
      st_push <= push_nxt;
      if (push_nxt) begin
        st_din <= res;
      end
      st_pop <= (state_nxt == S_POP1) || (state_nxt == S_POP2);
      st_tos <= (state_nxt == S_TOS1);
      depth  <= depth_nxt;
    end
  end

`ifdef STACK_SEQ_HIWATER_EN
  // peak depth since reset; a readout restarts tracking from the current depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      hiwater <= '0;
    end else if ((state == S_IDLE) && cmd_valid && hw_rd) begin
      hiwater <= depth_nxt;
    end else if (depth_nxt > hiwater) begin
      hiwater <= depth_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Purpose : directed self-checking bench for stack_op_sequencer with a behavioural 31-entry stack.
// Latency : checks accept-to-response latency, data, error flag and depth per op.
// Backpr. : commands are offered in IDLE; one case holds cmd_valid across a busy op.
module tb_stack_op_sequencer;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_TOS  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [4:0] depth;
  logic       st_clr;
  logic       st_push;
  logic       st_pop;
  logic       st_tos;
  logic [7:0] st_din;
  logic [7:0] st_dout = 8'h00;
`ifdef STACK_SEQ_HIWATER_EN
  logic [4:0] hiwater;
`endif

  int errors = 0;
  int checks = 0;
  int pops_seen = 0;
  int overlap = 0;
  int accepts = 0;

  logic [7:0] mem [0:30];
  int         head = 0;

  stack_op_sequencer #(.DEPTH(31), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .depth    (depth),
    .st_clr   (st_clr),
    .st_push  (st_push),
    .st_pop   (st_pop),
    .st_tos   (st_tos),
    .st_din   (st_din),
    .st_dout  (st_dout)
`ifdef STACK_SEQ_HIWATER_EN
    ,
    .hiwater  (hiwater)
`endif
  );

  always #5 clk = ~clk;

  // behavioural LIFO: read data appears the cycle after a pop/peek edge
  always @(posedge clk) begin
    if (st_clr) begin
      head <= 0;
    end else if (st_push) begin
      if (head < 31) begin
        mem[head] <= st_din;
        head      <= head + 1;
      end
    end else if (st_pop) begin
      if (head > 0) begin
        st_dout <= mem[head-1];
        head    <= head - 1;
      end
    end else if (st_tos) begin
      if (head > 0) begin
        st_dout <= mem[head-1];
      end
    end
  end

  // strobe activity and handshake monitors
  always @(posedge clk) begin
    if (st_pop) pops_seen++;
    if ((32'(st_push) + 32'(st_pop) + 32'(st_tos)) > 1) overlap++;
    if (rst && cmd_valid && cmd_ready) accepts++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] d, input int exp_lat,
                       input logic [7:0] exp_d, input logic exp_e, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) cmd_valid = 1'b0;
      if (rsp_valid) lat = i;
    end
    cmd_valid = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
  endtask

  task automatic check_depth(input logic [4:0] exp, input string tag);
    @(negedge clk);
    chk(tag, 32'(depth), 32'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  acc0;
    int  rsp_seen;
    bit  got;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.ready",   32'(cmd_ready), 32'd1);
    chk("rst.depth",   32'(depth),     32'd0);
    chk("rst.rsp_vld", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err),   32'd0);
    chk("rst.rsp_dat", 32'(rsp_data),  32'd0);
    chk("rst.push",    32'(st_push),   32'd0);
    chk("rst.pop",     32'(st_pop),    32'd0);
    chk("rst.tos",     32'(st_tos),    32'd0);
    chk("rst.din",     32'(st_din),    32'd0);
    chk("rst.clr",     32'(st_clr),    32'd1);
    rst = 1'b1;
    #1;
    chk("rst.clr_off", 32'(st_clr), 32'd0);

    // underflow rejects never touch the stack
    do_op(OP_POP,  8'h00, 1, 8'h00, 1'b1, "pop_empty");
    do_op(OP_ADD,  8'h00, 1, 8'h00, 1'b1, "add_empty");
    do_op(OP_PUSH, 8'h07, 2, 8'h07, 1'b0, "push7");
    do_op(OP_ADD,  8'h00, 1, 8'h00, 1'b1, "add_depth1");
    chk("no_pop_on_err", 32'(pops_seen), 32'd0);
    check_depth(5'd1, "depth_after_err");
    do_op(OP_POP,  8'h00, 3, 8'h07, 1'b0, "pop7");
    check_depth(5'd0, "depth_after_pop7");

    // SUB is second minus top
    do_op(OP_PUSH, 8'h05, 2, 8'h05, 1'b0, "push5");
    do_op(OP_PUSH, 8'h03, 2, 8'h03, 1'b0, "push3");
    do_op(OP_SUB,  8'h00, 4, 8'h02, 1'b0, "sub_5_3");
    check_depth(5'd1, "depth_sub1");
    do_op(OP_PUSH, 8'h03, 2, 8'h03, 1'b0, "push3b");
    do_op(OP_PUSH, 8'h05, 2, 8'h05, 1'b0, "push5b");
    do_op(OP_SUB,  8'h00, 4, 8'hFE, 1'b0, "sub_3_5");
    check_depth(5'd2, "depth_sub2");
    do_op(OP_POP,  8'h00, 3, 8'hFE, 1'b0, "pop_fe");
    do_op(OP_POP,  8'h00, 3, 8'h02, 1'b0, "pop_02");
    check_depth(5'd0, "depth_empty1");

    // wrap-around ADD, NOT, DUP, AND
    do_op(OP_PUSH, 8'hFF, 2, 8'hFF, 1'b0, "push_ff");
    do_op(OP_PUSH, 8'h02, 2, 8'h02, 1'b0, "push_02");
    do_op(OP_ADD,  8'h00, 4, 8'h01, 1'b0, "add_wrap");
    do_op(OP_NOT,  8'h00, 3, 8'hFE, 1'b0, "not_01");
    do_op(OP_DUP,  8'h00, 3, 8'hFE, 1'b0, "dup_fe");
    check_depth(5'd2, "depth_dup");
    do_op(OP_PUSH, 8'h0F, 2, 8'h0F, 1'b0, "push_0f");
    do_op(OP_AND,  8'h00, 4, 8'h0E, 1'b0, "and_fe_0f");
    do_op(OP_POP,  8'h00, 3, 8'h0E, 1'b0, "pop_0e");
    do_op(OP_POP,  8'h00, 3, 8'hFE, 1'b0, "pop_fe2");
    check_depth(5'd0, "depth_empty2");

    // fill to capacity, then overflow rejects
    for (int i = 0; i < 31; i++) begin
      do_op(OP_PUSH, 8'(i), 2, 8'(i), 1'b0, "fill");
    end
    check_depth(5'd31, "depth_full");
    do_op(OP_PUSH, 8'h55, 1, 8'h00, 1'b1, "push_full");
    do_op(OP_DUP,  8'h00, 1, 8'h00, 1'b1, "dup_full");
    check_depth(5'd31, "depth_full_kept");
    do_op(OP_POP,  8'h00, 3, 8'h1E, 1'b0, "pop_1e");
    do_op(OP_TOS,  8'h00, 3, 8'h1D, 1'b0, "tos_1d");
    check_depth(5'd30, "depth_after_tos");

    // reset while POP2 of an ADD is in flight
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst.pop2_strobe", 32'(st_pop), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst.clr", 32'(st_clr), 32'd1);
    @(negedge clk);
    chk("midrst.idle",  32'(cmd_ready), 32'd1);
    chk("midrst.depth", 32'(depth),     32'd0);
    chk("midrst.rsp",   32'(rsp_valid), 32'd0);
    rst = 1'b1;
    rsp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    chk("midrst.no_rsp", 32'(rsp_seen), 32'd0);

`ifdef STACK_SEQ_HIWATER_EN
    // peak depth tracking and readout
    do_op(OP_PUSH, 8'h01, 2, 8'h01, 1'b0, "hw_push1");
    do_op(OP_PUSH, 8'h02, 2, 8'h02, 1'b0, "hw_push2");
    do_op(OP_PUSH, 8'h03, 2, 8'h03, 1'b0, "hw_push3");
    do_op(OP_POP,  8'h00, 3, 8'h03, 1'b0, "hw_pop3");
    do_op(OP_POP,  8'h00, 3, 8'h02, 1'b0, "hw_pop2");
    check_depth(5'd1, "hw_depth");
    chk("hw_peak", 32'(hiwater), 32'd3);
    do_op(OP_NOT,  8'h80, 1, 8'h03, 1'b0, "hw_read");
    check_depth(5'd1, "hw_read_depth");
    chk("hw_cleared", 32'(hiwater), 32'd1);
    do_op(OP_POP,  8'h00, 3, 8'h01, 1'b0, "hw_pop1");
`endif

    // cmd_valid held through a busy op is accepted once
    do_op(OP_PUSH, 8'h42, 2, 8'h42, 1'b0, "push42");
    acc0 = accepts;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_POP;
    cmd_data  = 8'h00;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    cmd_valid = 1'b0;
    chk("held.rsp",     32'(got),           32'd1);
    chk("held.data",    32'(rsp_data),      32'h42);
    chk("held.accepts", 32'(accepts - acc0), 32'd1);
    check_depth(5'd0, "held.depth");

    // global invariants
    chk("strobe_overlap", 32'(overlap), 32'd0);
    chk("depth_vs_head",  32'(depth),   32'(head));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
